photon_bin_scheduler: RTL and testbench

PHOTON_BIN_SCHEDULER -- requirements
Module: photon_bin_scheduler

---
 rtl/photon_sched_pkg.sv | 20 ++
 rtl/photon_bin_scheduler_sat_counter.sv | 31 +++
 rtl/photon_bin_scheduler.sv | 148 ++++++++++++++
 tb/tb_photon_bin_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/photon_sched_pkg.sv
// Shared constants for the photon phase-bin scheduler.
//   NBINS      : default number of phase-bin detector lines
//   CNT_W      : default width of each per-bin hit counter
//   WIN_W      : default width of the acquisition window length
//   ARM_CYCLES : settle time for the edge-detector veto before counting starts
//   ST_*       : scheduler state encoding
package photon_sched_pkg;

   localparam int NBINS      = 10;
   localparam int CNT_W      = 16;
   localparam int WIN_W      = 24;
   localparam int ARM_CYCLES = 4;
   localparam int ARM_W      = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARM     = 2'd1;
   localparam logic [1:0] ST_ACQUIRE = 2'd2;
   localparam logic [1:0] ST_REPORT  = 2'd3;

endpackage

// File: rtl/photon_bin_scheduler_sat_counter.sv
// Saturating up-counter used for each phase bin and for the multi-hit tally.
//   clk   : clock
//   rstn  : asynchronous active-low reset
//   clr   : synchronous clear (wins over inc)
//   inc   : add one, unless already at all-ones
//   count : current value
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != '1)) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/photon_bin_scheduler.sv
// Photon phase-bin scheduler: arms the edge-detector veto, counts detector
// pulses per phase bin over a programmed window, then reads the NBINS bin
// counts plus a multi-hit count out over a valid/ready handshake.
//   clk, rstn            : clock, asynchronous active-low reset
//   start, abort         : run request / cancel
//   window_len, veto_cfg : run configuration, captured on an accepted start
//   det                  : per-bin detection pulses
//   veto_last            : veto configuration of the latest accepted run
//   busy, done           : run in progress / one-cycle completion pulse
//   rd_valid, rd_ready   : readout handshake
//   rd_bin, rd_count     : readout index (NBINS = multi-hit) and its count
//   rd_last              : final readout word
module photon_bin_scheduler #(
   parameter int NBINS = photon_sched_pkg::NBINS,
   parameter int CNT_W = photon_sched_pkg::CNT_W,
   parameter int WIN_W = photon_sched_pkg::WIN_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             abort,
   input  logic [WIN_W-1:0] window_len,
   input  logic [2:0]       veto_cfg,
   input  logic [NBINS-1:0] det,
   output logic [2:0]       veto_last,
   output logic             busy,
   output logic             done,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [3:0]       rd_bin,
   output logic [CNT_W-1:0] rd_count,
   output logic             rd_last
);

   import photon_sched_pkg::*;

   localparam logic [3:0] LAST_IDX = 4'(NBINS);

   logic [1:0]       state_reg;
   logic [ARM_W-1:0] arm_cnt_reg;
   logic [WIN_W-1:0] win_cnt_reg;   // cycles of ACQUIRE still to run
   logic [2:0]       veto_reg;
   logic [3:0]       rd_bin_reg;
   logic             done_reg;
   logic             accept;
   logic             acquire;
   logic [NBINS:0]   inc;
   logic [CNT_W-1:0] cnt_arr [NBINS+1];

   assign accept  = (state_reg == ST_IDLE) && start && !abort && (window_len != '0);
   assign acquire = (state_reg == ST_ACQUIRE);

   generate
      for (genvar gi = 0; gi < NBINS; gi++) begin : g_bin_inc
         assign inc[gi] = acquire && det[gi];
      end
   endgenerate

   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign inc[NBINS] = acquire && ((det & (det - NBINS'(1))) != '0);

   // Counters clear on the accepting edge, so they are zero when ARM begins.
   generate
      for (genvar gi = 0; gi <= NBINS; gi++) begin : g_cnt
         sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rstn  (rstn),
            .clr   (accept),
            .inc   (inc[gi]),
            .count (cnt_arr[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg   <= ST_IDLE;
         arm_cnt_reg <= '0;
         win_cnt_reg <= '0;
         veto_reg    <= '0;
         rd_bin_reg  <= '0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  state_reg   <= ST_ARM;
                  win_cnt_reg <= window_len;
                  veto_reg    <= veto_cfg;
                  arm_cnt_reg <= '0;
               end
            end
            ST_ARM: begin
               if (abort) begin
                  state_reg <= ST_IDLE;
               end else if (arm_cnt_reg == ARM_W'(ARM_CYCLES - 1)) begin
                  state_reg <= ST_ACQUIRE;
               end else begin
                  arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
               end
            end
            ST_ACQUIRE: begin
               // Down-count stops at 1, so a full-scale window never wraps.
               if (abort) begin
                  state_reg <= ST_IDLE;
               end else if (win_cnt_reg == WIN_W'(1)) begin
                  state_reg  <= ST_REPORT;
                  rd_bin_reg <= '0;
               end else begin
                  win_cnt_reg <= win_cnt_reg - WIN_W'(1);
               end
            end
            ST_REPORT: begin
               if (abort) begin
                  state_reg <= ST_IDLE;
               end else if (rd_ready) begin
                  if (rd_bin_reg == LAST_IDX) begin
                     state_reg <= ST_IDLE;
                     done_reg  <= 1'b1;
                  end else begin
                     rd_bin_reg <= rd_bin_reg + 4'd1;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Counts are frozen in REPORT, so a plain mux holds rd_count steady on stalls.
   always_comb begin
      rd_count = '0;
      for (int i = 0; i <= NBINS; i++) begin
         if (rd_bin_reg == 4'(i)) begin
            rd_count = cnt_arr[i];
         end
      end
   end

   assign rd_valid  = (state_reg == ST_REPORT);
   assign rd_bin    = rd_bin_reg;
   assign rd_last   = rd_valid && (rd_bin_reg == LAST_IDX);
   assign busy      = (state_reg != ST_IDLE);
   assign done      = done_reg;
   assign veto_last = veto_reg;

endmodule

// File: tb/tb_photon_bin_scheduler.sv
// Directed-plus-random bench for photon_bin_scheduler. A 16-bit and a 4-bit
// counter instance share all stimulus; expected counts are totals of the det
// words driven during the acquisition window, clipped to each counter range.
module tb_photon_bin_scheduler;

   import photon_sched_pkg::*;

   localparam int NB = NBINS;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic          abort;
   logic [23:0]   window_len;
   logic [2:0]    veto_cfg;
   logic [NB-1:0] det;
   logic          rd_ready;

   logic [2:0]  veto_last,   veto_last_s;
   logic        busy,        busy_s;
   logic        done,        done_s;
   logic        rd_valid,    rd_valid_s;
   logic [3:0]  rd_bin,      rd_bin_s;
   logic [15:0] rd_count;
   logic [3:0]  rd_count_s;
   logic        rd_last,     rd_last_s;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   int exp_cnt [NB+1];

   photon_bin_scheduler dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort),
      .window_len(window_len), .veto_cfg(veto_cfg), .det(det),
      .veto_last(veto_last), .busy(busy), .done(done),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bin(rd_bin),
      .rd_count(rd_count), .rd_last(rd_last)
   );

   photon_bin_scheduler #(.NBINS(NB), .CNT_W(4), .WIN_W(24)) dut_s (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort),
      .window_len(window_len), .veto_cfg(veto_cfg), .det(det),
      .veto_last(veto_last_s), .busy(busy_s), .done(done_s),
      .rd_valid(rd_valid_s), .rd_ready(rd_ready), .rd_bin(rd_bin_s),
      .rd_count(rd_count_s), .rd_last(rd_last_s)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done === 1'b1) done_seen++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int clip(input int v, input int w);
      int top;
      top = (1 << w) - 1;
      return (v > top) ? top : v;
   endfunction

   function automatic logic [NB-1:0] gen_det(input int mode);
      logic [NB-1:0] d;
      case (mode)
         0:       d = NB'(1);
         1:       d = 10'b1000000011;
         2:       d = 10'b0000000100;
         default: d = NB'($urandom);
      endcase
      return d;
   endfunction

   // One complete run: start, ARM with random (ignored) det, ACQUIRE with the
   // chosen det pattern, then drain the readout and check the done pulse.
   task automatic do_run(input int wl, input logic [2:0] vc, input int det_mode,
                         input bit rnd_ready, input bit busy_start);
      logic [NB-1:0] d;
      int idx;
      int budget;
      int dpre;
      for (int i = 0; i <= NB; i++) exp_cnt[i] = 0;
      dpre       = done_seen;
      start      = 1'b1;
      window_len = 24'(wl);
      veto_cfg   = vc;
      abort      = 1'b0;
      tick();
      start      = 1'b0;
      veto_cfg   = 3'($urandom);
      window_len = 24'($urandom);
      chk("busy_arm", 32'(busy), 32'(1));
      chk("veto_last", 32'(veto_last), 32'(vc));
      for (int k = 0; k < ARM_CYCLES; k++) begin
         det = NB'($urandom);
         if (busy_start && k == 1) begin
            start      = 1'b1;
            window_len = 24'd3;
            veto_cfg   = ~vc;
         end
         tick();
         start = 1'b0;
      end
      for (int c = 0; c < wl; c++) begin
         chk("acq_no_valid", 32'(rd_valid), 32'(0));
         d   = gen_det(det_mode);
         det = d;
         if (busy_start && c == 0) begin
            start      = 1'b1;
            window_len = 24'd2;
         end
         tick();
         start = 1'b0;
         for (int i = 0; i < NB; i++) if (d[i]) exp_cnt[i]++;
         if ($countones(d) >= 2) exp_cnt[NB]++;
      end
      det = NB'($urandom);
      chk("rd_valid_first", 32'(rd_valid), 32'(1));
      idx    = 0;
      budget = 0;
      while (idx <= NB && budget < 200) begin
         rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         chk("rd_valid", 32'(rd_valid), 32'(1));
         chk("rd_bin", 32'(rd_bin), 32'(idx));
         chk("rd_count", 32'(rd_count), 32'(clip(exp_cnt[idx], 16)));
         chk("rd_count_sat", 32'(rd_count_s), 32'(clip(exp_cnt[idx], 4)));
         chk("rd_last", 32'(rd_last), 32'(idx == NB));
         chk("done_early", 32'(done), 32'(0));
         if (rd_ready && rd_valid) idx++;
         tick();
         det = NB'($urandom);
         budget++;
      end
      rd_ready = 1'b0;
      chk("xfer_count", 32'(idx), 32'(NB + 1));
      chk("done_pulse", 32'(done), 32'(1));
      chk("busy_end", 32'(busy), 32'(0));
      chk("valid_end", 32'(rd_valid), 32'(0));
      tick();
      chk("done_one_cycle", 32'(done), 32'(0));
      chk("veto_hold", 32'(veto_last), 32'(vc));
      chk("done_count", 32'(done_seen - dpre), 32'(1));
      $display("run wl=%0d veto=%0b mode=%0d rnd_ready=%0d busy_start=%0d: bin0=%0d multi=%0d",
               wl, vc, det_mode, rnd_ready, busy_start, exp_cnt[0], exp_cnt[NB]);
   endtask

   initial begin
      int dpre;
      rstn       = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      window_len = '0;
      veto_cfg   = '0;
      det        = '0;
      rd_ready   = 1'b0;
      tick();
      tick();
      chk("rst_veto", 32'(veto_last), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_valid", 32'(rd_valid), 32'(0));
      chk("rst_bin", 32'(rd_bin), 32'(0));
      chk("rst_count", 32'(rd_count), 32'(0));
      chk("rst_last", 32'(rd_last), 32'(0));
      rstn = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 32'(0));
      $display("reset checks done");

      do_run(8, 3'b101, 0, 1'b0, 1'b0);
      do_run(3, 3'b010, 1, 1'b0, 1'b0);
      do_run(20, 3'b111, 2, 1'b0, 1'b0);
      do_run(12, 3'b011, 3, 1'b1, 1'b0);

      // Abort on the third ACQUIRE cycle.
      dpre       = done_seen;
      start      = 1'b1;
      window_len = 24'd10;
      veto_cfg   = 3'b110;
      tick();
      start = 1'b0;
      for (int k = 0; k < ARM_CYCLES + 2; k++) begin
         det = NB'($urandom);
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_valid", 32'(rd_valid), 32'(0));
      for (int k = 0; k < 15; k++) begin
         det = NB'($urandom);
         chk("abort_idle_valid", 32'(rd_valid), 32'(0));
         tick();
      end
      chk("abort_no_done", 32'(done_seen - dpre), 32'(0));
      chk("abort_veto_hold", 32'(veto_last), 32'(3'b110));
      $display("abort run checked");

      do_run(5, 3'b001, 3, 1'b1, 1'b1);

      // Starts that must be ignored in IDLE.
      start      = 1'b1;
      window_len = 24'd0;
      veto_cfg   = 3'b111;
      tick();
      start = 1'b0;
      chk("zero_len_busy", 32'(busy), 32'(0));
      chk("zero_len_veto", 32'(veto_last), 32'(3'b001));
      start      = 1'b1;
      abort      = 1'b1;
      window_len = 24'd5;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", 32'(busy), 32'(0));
      chk("start_abort_veto", 32'(veto_last), 32'(3'b001));
      tick();
      chk("ignored_busy_later", 32'(busy), 32'(0));
      $display("ignored starts checked");

      // Reset mid-run discards the run without a done pulse.
      dpre       = done_seen;
      start      = 1'b1;
      window_len = 24'd30;
      veto_cfg   = 3'b100;
      tick();
      start = 1'b0;
      for (int k = 0; k < ARM_CYCLES + 5; k++) begin
         det = '1;
         tick();
      end
      rstn = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'(0));
      chk("midrst_veto", 32'(veto_last), 32'(0));
      chk("midrst_count", 32'(rd_count), 32'(0));
      tick();
      rstn = 1'b1;
      for (int k = 0; k < 40; k++) begin
         det = NB'($urandom);
         chk("midrst_valid", 32'(rd_valid), 32'(0));
         tick();
      end
      chk("midrst_no_done", 32'(done_seen - dpre), 32'(0));
      $display("reset mid-run checked");

      do_run(4, 3'b100, 3, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
